// File: rtl/requant_sat_pipe.sv
// requant_sat_pipe
// ----------------
// Two-stage valid/ready requantiser for the NPU accumulator-to-activation path.
// Each lane takes a signed IN_W accumulator value. Stage 1 applies an arithmetic
// right shift with round-half-up. Stage 2 applies optional ReLU and signed
// saturation to OUT_W. A saturating counter records how many delivered
// lane-results were clamped.
//
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   in_valid   : input beat valid
//   in_ready   : block can accept a beat; does not depend on in_valid
//   in_data    : LANES packed signed lanes, lane i at [i*IN_W +: IN_W]
//   in_shift   : right-shift amount, captured with the beat
//   in_relu    : clamp negatives to zero, captured with the beat
//   out_valid  : output beat valid (registered)
//   out_ready  : downstream accepts the beat
//   out_data   : LANES packed signed results, lane i at [i*OUT_W +: OUT_W]
//   sat_cnt    : saturating count of clamped lane-results delivered
//   sat_clr    : clear sat_cnt; takes priority over a coincident increment
module requant_sat_pipe #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 8,
  parameter int LANES = 4,
  parameter int SH_W  = $clog2(IN_W),
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*IN_W-1:0]  in_data,
  input  logic [SH_W-1:0]        in_shift,
  input  logic                   in_relu,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*OUT_W-1:0] out_data,
  output logic [CNT_W-1:0]       sat_cnt,
  input  logic                   sat_clr
);

  // One extra bit keeps (x + rounding bias) from overflowing at the largest shift.
  localparam int RW = IN_W + 1;
  localparam int PW = $clog2(LANES + 1);
  localparam int SW = CNT_W + PW;

  localparam logic signed [RW-1:0] SAT_MAX = {{(RW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [RW-1:0] SAT_MIN = {{(RW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0]     OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0]     OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [SW-1:0]        CNT_MAX = {{PW{1'b0}}, {CNT_W{1'b1}}};

  // Sign-extend, add half an output LSB, then shift arithmetically.
  // Ties therefore round toward +inf.
  function automatic logic [RW-1:0] round_shift(input logic [IN_W-1:0] x,
                                                input logic [SH_W-1:0] sh);
    logic signed [RW-1:0] xe;
    logic signed [RW-1:0] bias;
    xe   = $signed({x[IN_W-1], x});
    bias = '0;
    if (sh == '0) begin
      round_shift = xe;
    end else begin
      bias        = RW'(1) << (sh - SH_W'(1));
      round_shift = (xe + bias) >>> sh;
    end
  endfunction

  // Returns {clamped_flag, result}. A ReLU zeroing is not counted as a clamp.
  function automatic logic [OUT_W:0] sat_lane(input logic [RW-1:0] r,
                                              input logic relu);
    logic signed [RW-1:0] v;
    v = (relu && r[RW-1]) ? '0 : $signed(r);
    if (v > SAT_MAX) begin
      sat_lane = {1'b1, OUT_MAX};
    end else if (v < SAT_MIN) begin
      sat_lane = {1'b1, OUT_MIN};
    end else begin
      sat_lane = {1'b0, v[OUT_W-1:0]};
    end
  endfunction

  // Adds the popcount of the flags to the counter, sticking at all-ones.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                               input logic [LANES-1:0] flags);
    logic [SW-1:0] sum;
    sum = {{PW{1'b0}}, cnt};
    for (int i = 0; i < LANES; i++) begin
      sum = sum + {{(SW-1){1'b0}}, flags[i]};
    end
    if (sum > CNT_MAX) begin
      sat_add = {CNT_W{1'b1}};
    end else begin
      sat_add = sum[CNT_W-1:0];
    end
  endfunction

  logic                   r_s1_valid;
  logic [LANES*RW-1:0]    r_s1_data;
  logic                   r_s1_relu;
  logic                   r_s2_valid;
  logic [LANES*OUT_W-1:0] r_out_data;
  logic [LANES-1:0]       r_sat;
  logic [CNT_W-1:0]       r_sat_cnt;

  logic                   w_s1_ready;
  logic                   w_in_ready;
  logic [LANES*RW-1:0]    w_s1_data;
  logic [LANES*OUT_W-1:0] w_s2_data;
  logic [LANES-1:0]       w_s2_sat;

  assign w_s1_ready = !r_s2_valid || out_ready;
  assign w_in_ready = !r_s1_valid || w_s1_ready;

  // Stage 1 datapath: per-lane rounding shift of the incoming beat.
  always_comb begin
    w_s1_data = '0;
    for (int i = 0; i < LANES; i++) begin
      w_s1_data[i*RW +: RW] = round_shift(in_data[i*IN_W +: IN_W], in_shift);
    end
  end

  // Stage 2 datapath: per-lane ReLU and saturation of the stage-1 value.
  always_comb begin
    w_s2_data = '0;
    w_s2_sat  = '0;
    for (int i = 0; i < LANES; i++) begin
      {w_s2_sat[i], w_s2_data[i*OUT_W +: OUT_W]} = sat_lane(r_s1_data[i*RW +: RW], r_s1_relu);
    end
  end

  // Pipeline registers. Stage 2 is the output register.
  // Stage 2 loads only when its contents drain or it is empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_relu  <= 1'b0;
      r_s2_valid <= 1'b0;
      r_out_data <= '0;
      r_sat      <= '0;
    end else begin
      if (w_s1_ready) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_out_data <= w_s2_data;
          r_sat      <= w_s2_sat;
        end
      end
      if (w_in_ready) begin
        r_s1_valid <= in_valid;
        if (in_valid) begin
          r_s1_data <= w_s1_data;
          r_s1_relu <= in_relu;
        end
      end
    end
  end

  // Saturation-event counter. It counts once per delivered beat, and a clear beats an increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sat_cnt <= '0;
    end else if (sat_clr) begin
      r_sat_cnt <= '0;
    end else if (r_s2_valid && out_ready) begin
      r_sat_cnt <= sat_add(r_sat_cnt, r_sat);
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_s2_valid;
  assign out_data  = r_out_data;
  assign sat_cnt   = r_sat_cnt;

endmodule

// File: tb/tb_requant_sat_pipe.sv
// Scoreboard bench for requant_sat_pipe (IN_W=16, OUT_W=8, LANES=4, CNT_W=4).
// The driver pushes the expected beat when the DUT accepts it. A separate
// monitor pops and compares whenever an output transfer is presented.
module tb_requant_sat_pipe;
  localparam int IN_W  = 16;
  localparam int OUT_W = 8;
  localparam int LANES = 4;
  localparam int SH_W  = 4;
  localparam int CNT_W = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*IN_W-1:0]  in_data;
  logic [SH_W-1:0]        in_shift;
  logic                   in_relu;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*OUT_W-1:0] out_data;
  logic [CNT_W-1:0]       sat_cnt;
  logic                   sat_clr;

  requant_sat_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .LANES(LANES), .SH_W(SH_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_shift(in_shift), .in_relu(in_relu), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .sat_cnt(sat_cnt), .sat_clr(sat_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          pres;
    bit          chk_lat;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  bit          stalled = 1'b0;
  logic [31:0] held = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // The beat is pushed only if in_ready was high while it was presented.
  // The presentation cycle is recorded so that latency can be checked.
  task automatic send(input int l0, input int l1, input int l2, input int l3,
                      input int sh, input bit relu,
                      input int e0, input int e1, input int e2, input int e3,
                      input bit chk);
    exp_t e;
    bit   acc;
    int   tries;
    acc = 1'b0;
    tries = 0;
    e.data = {8'(e3), 8'(e2), 8'(e1), 8'(e0)};
    e.chk_lat = chk;
    e.pres = 0;
    while (!acc && tries < 50) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = {16'(l3), 16'(l2), 16'(l1), 16'(l0)};
      in_shift = 4'(sh);
      in_relu  = relu;
      e.pres   = cyc;
      #2;
      acc = in_ready;
      @(posedge clk);
      tries++;
    end
    if (acc) begin
      sb.push_back(e);
    end else begin
      total++;
      bad++;
      $display("FAIL send_timeout: in_ready stayed low for %0d cycles", tries);
    end
  endtask

  // Wait, with a bound, until every expected beat has been delivered.
  // Then allow the final transfer edge to update sat_cnt.
  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      in_valid = 1'b0;
      #3;
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: %0d beats still expected", sb.size());
    end
    @(negedge clk);
    in_valid = 1'b0;
    #3;
  endtask

  // Monitor: compares delivered beats in order and checks that stalled outputs hold.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          check("hold_valid", 64'(out_valid), 64'd1);
          check("hold_data", 64'(out_data), 64'(held));
        end
        if (out_valid && !out_ready) begin
          stalled = 1'b1;
          held    = out_data;
        end else begin
          stalled = 1'b0;
          if (out_valid) begin
            if (sb.size() == 0) begin
              total++;
              bad++;
              $display("FAIL extra_beat: got 0x%0h with nothing expected", out_data);
            end else begin
              e = sb.pop_front();
              check("out_data", 64'(out_data), 64'(e.data));
              if (e.chk_lat) check("latency", 64'(cyc - e.pres), 64'd2);
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_shift = '0; in_relu = 1'b0;
    out_ready = 1'b1; sat_clr = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_sat_cnt", 64'(sat_cnt), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);

    // Basic saturation, rounding, ReLU and shift boundaries.
    send(300, -300, 100, -128, 0, 1'b0, 127, -128, 100, -128, 1'b1);
    drain();
    check("sat_cnt_t1", 64'(sat_cnt), 64'd2);
    send(24, 23, -24, -25, 4, 1'b0, 2, 1, -1, -2, 1'b1);
    send(-5, 0, 5, 200, 0, 1'b1, 0, 0, 5, 127, 1'b1);
    send(-32768, 32767, 16384, -16385, 15, 1'b0, -1, 1, 1, -1, 1'b1);
    send(3, -3, 1, -1, 1, 1'b0, 2, -1, 1, 0, 1'b1);
    send(-1, -2, -3, 1000, 2, 1'b1, 0, 0, 0, 127, 1'b1);
    send(255, -257, 254, -256, 1, 1'b0, 127, -128, 127, -128, 1'b1);
    drain();
    check("sat_cnt_mix", 64'(sat_cnt), 64'd5);
    @(negedge clk); sat_clr = 1'b1;
    @(negedge clk); sat_clr = 1'b0; #2;
    check("sat_clr_idle", 64'(sat_cnt), 64'd0);

    // Backpressure: out_ready is low for cycles 2-4 of a 6-beat stream.
    fork
      begin
        for (int k = 1; k <= 6; k++) send(k, -k, k + 1, 0, 0, 1'b0, k, -k, k + 1, 0, 1'b0);
      end
      begin
        for (int c = 0; c < 8; c++) begin
          @(negedge clk);
          out_ready = !(c >= 2 && c <= 4);
          #2;
          if (c == 3) check("bp_in_ready_full", 64'(in_ready), 64'd0);
        end
      end
    join
    drain();
    send(9, 8, 7, 6, 0, 1'b0, 9, 8, 7, 6, 1'b1);
    drain();
    check("sat_cnt_bp", 64'(sat_cnt), 64'd0);

    // Counter preload to 14, then saturation at 15, then clear beats a coincident increment.
    for (int j = 0; j < 3; j++) send(200, -200, 300, -300, 0, 1'b0, 127, -128, 127, -128, 1'b0);
    send(200, -200, 1, 2, 0, 1'b0, 127, -128, 1, 2, 1'b0);
    drain();
    check("sat_cnt_14", 64'(sat_cnt), 64'd14);
    send(200, -200, 300, -300, 0, 1'b0, 127, -128, 127, -128, 1'b0);
    drain();
    check("sat_cnt_15", 64'(sat_cnt), 64'd15);
    send(200, -200, 300, -300, 0, 1'b0, 127, -128, 127, -128, 1'b0);
    drain();
    check("sat_cnt_hold", 64'(sat_cnt), 64'd15);
    send(200, -200, 300, -300, 0, 1'b0, 127, -128, 127, -128, 1'b1);
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk); sat_clr = 1'b1; #2;
    check("clr_coincident_valid", 64'(out_valid), 64'd1);
    @(negedge clk); sat_clr = 1'b0; #2;
    check("sat_cnt_clr_wins", 64'(sat_cnt), 64'd0);

    // Reset while both stages hold beats.
    send(200, -200, 300, -300, 0, 1'b0, 127, -128, 127, -128, 1'b0);
    drain();
    check("sat_cnt_pre_rst", 64'(sat_cnt), 64'd4);
    out_ready = 1'b0;
    send(1, 2, 3, 4, 0, 1'b0, 1, 2, 3, 4, 1'b0);
    send(500, 6, 7, 8, 0, 1'b0, 127, 6, 7, 8, 1'b0);
    @(negedge clk); in_valid = 1'b0; #2;
    check("full_out_valid", 64'(out_valid), 64'd1);
    check("full_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk); rst = 1'b1; sb.delete();
    @(negedge clk); rst = 1'b0; #2;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_sat_cnt", 64'(sat_cnt), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    send(-7, 70, -70, 7, 1, 1'b0, -3, 35, -35, 4, 1'b1);
    drain();
    check("sat_cnt_post_rst", 64'(sat_cnt), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
